// File: rtl/pet_pkg.sv
// -----------------------------------------------------------------------------
// pet_pkg
// Shared codes and types for the pet status engine:
//   - mood codes driven on select_figures[3:2]
//   - icon codes driven on select_figures[1:0]
//   - stat and button index constants
//   - activity FSM states and the accepted-action encoding
//   - next_icon(): the idle icon rotation order
// No ports (package).
// -----------------------------------------------------------------------------
package pet_pkg;

    typedef enum logic [1:0] {
        MOOD_SAD     = 2'b00,
        MOOD_HAPPY   = 2'b01,
        MOOD_NEUTRAL = 2'b10
    } mood_e;

    typedef enum logic [1:0] {
        ICON_HEALTH = 2'b00,
        ICON_ENERGY = 2'b01,
        ICON_FOOD   = 2'b10,
        ICON_FUN    = 2'b11
    } icon_e;

    // Stat slots, also the field order of stat_levels (food in the LSBs)
    localparam int STAT_FOOD   = 0;
    localparam int STAT_ENERGY = 1;
    localparam int STAT_FUN    = 2;
    localparam int STAT_HEALTH = 3;
    localparam int NUM_STATS   = 4;

    // Button slots of the conditioned press vector
    localparam int BTN_FEED  = 0;
    localparam int BTN_PLAY  = 1;
    localparam int BTN_SLEEP = 2;
    localparam int BTN_HEAL  = 3;
    localparam int NUM_BTNS  = 4;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_SLEEP  = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_HEAL  = 3'd1,
        ACT_FEED  = 3'd2,
        ACT_PLAY  = 3'd3,
        ACT_SLEEP = 3'd4
    } action_e;

    // Idle rotation: health -> food -> energy -> fun -> health
    function automatic icon_e next_icon(input icon_e cur);
        icon_e nxt;
        case (cur)
            ICON_HEALTH: nxt = ICON_FOOD;
            ICON_FOOD:   nxt = ICON_ENERGY;
            ICON_ENERGY: nxt = ICON_FUN;
            ICON_FUN:    nxt = ICON_HEALTH;
            default:     nxt = ICON_HEALTH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Turns one raw asynchronous active-high button into a single-cycle press
// pulse: 2-FF synchronizer, optional debounce, rising-edge detect.
// Optional feature macro: DEBOUNCE_EN (adds a DEBOUNCE_CYCLES stability filter).
// Without it the pulse is visible two cycles after the raw input rises.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-low reset (clears any pending edge)
//   raw    in   raw button level
//   press  out  one-cycle pulse per accepted 0->1 transition
// -----------------------------------------------------------------------------
module btn_conditioner
`ifdef DEBOUNCE_EN
    #(parameter int DEBOUNCE_CYCLES = 500_000)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    logic sync1_r;
    logic sync2_r;
    logic level_r;
    logic level_d_r;

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DBW-1:0] stable_cnt_r;

    // Accept a new level only after it has held for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk) begin
        if (!reset) begin
            stable_cnt_r <= '0;
            level_r      <= 1'b0;
        end else if (sync2_r == level_r) begin
            stable_cnt_r <= '0;
        end else if (stable_cnt_r == DBW'(DEBOUNCE_CYCLES - 1)) begin
            stable_cnt_r <= '0;
            level_r      <= sync2_r;
        end else begin
            stable_cnt_r <= stable_cnt_r + DBW'(1);
        end
    end
`else
    // No filtering: the synchronized level feeds the edge detector directly
    always_comb begin
        level_r = sync2_r;
    end
`endif

    // Previous level for rising-edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            level_d_r <= 1'b0;
        end else begin
            level_d_r <= level_r;
        end
    end

    assign press = level_r & ~level_d_r;

endmodule

// File: rtl/pet_status_engine.sv
// -----------------------------------------------------------------------------
// pet_status_engine
// Keeps four pet stats (food, energy, fun, health), decays them on a slow
// tick, replenishes them from user buttons, runs the ACTIVE/SLEEP activity
// FSM and produces the registered {mood, icon} code for the LCD controller.
// Optional feature macro: DEBOUNCE_EN (button debounce, DEBOUNCE_CYCLES).
// Ports:
//   clk             in   system clock
//   reset           in   synchronous, active-low reset
//   btn_feed/play/sleep/heal  in  raw asynchronous active-high buttons
//   select_figures  out  {mood[1:0], icon[1:0]}, registered
//   stat_levels     out  {health, fun, energy, food}, LVL_W bits each
//   sleeping        out  high while in SLEEP
//   update          out  one-cycle pulse when select_figures changes
// -----------------------------------------------------------------------------
module pet_status_engine
    import pet_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int DECAY_TICKS  = 10,
    parameter int ROTATE_TICKS = 3,
    parameter int MAX_LEVEL    = 5,
    parameter int INIT_LEVEL   = 3,
    parameter int HAPPY_TH     = 4,
    parameter int SAD_TH       = 1,
`ifdef DEBOUNCE_EN
    parameter int DEBOUNCE_CYCLES = 500_000,
`endif
    localparam int LVL_W = $clog2(MAX_LEVEL + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       btn_feed,
    input  logic                       btn_play,
    input  logic                       btn_sleep,
    input  logic                       btn_heal,
    output logic [3:0]                 select_figures,
    output logic [NUM_STATS*LVL_W-1:0] stat_levels,
    output logic                       sleeping,
    output logic                       update
);

    localparam int TW = (TICK_DIV > 1)     ? $clog2(TICK_DIV)     : 1;
    localparam int DW = (DECAY_TICKS > 1)  ? $clog2(DECAY_TICKS)  : 1;
    localparam int RW = (ROTATE_TICKS > 1) ? $clog2(ROTATE_TICKS) : 1;
    // Two spare bits hold the -2..MAX+2 range before the single saturation
    localparam int SW = LVL_W + 2;

    logic [NUM_BTNS-1:0] raw_s;
    logic [NUM_BTNS-1:0] press_s;
    logic [TW-1:0]       tick_cnt_r;
    logic [DW-1:0]       decay_cnt_r;
    logic [RW-1:0]       rot_cnt_r;
    logic [RW-1:0]       rot_nxt_s;
    logic                tick_s;
    logic                decay_ev_s;
    state_e              state_r;
    state_e              state_nxt_s;
    action_e             action_s;
    icon_e               icon_r;
    icon_e               icon_nxt_s;
    logic [LVL_W-1:0]    stat_r     [NUM_STATS];
    logic [LVL_W-1:0]    stat_nxt_s [NUM_STATS];
    logic signed [SW-1:0] delta_s   [NUM_STATS];
    logic [3:0]          sel_r;
    logic [3:0]          sel_nxt_s;
    logic                update_r;
    logic                sleeping_r;

    function automatic logic [LVL_W-1:0] sat(input logic signed [SW-1:0] v);
        logic [LVL_W-1:0] r;
        if (v[SW-1]) begin
            r = '0;
        end else if (v > SW'(MAX_LEVEL)) begin
            r = LVL_W'(MAX_LEVEL);
        end else begin
            r = v[LVL_W-1:0];
        end
        return r;
    endfunction

    function automatic mood_e mood_of(input logic [LVL_W-1:0] f, input logic [LVL_W-1:0] e,
                                      input logic [LVL_W-1:0] u, input logic [LVL_W-1:0] h);
        mood_e m;
        if (f <= LVL_W'(SAD_TH) || e <= LVL_W'(SAD_TH) ||
            u <= LVL_W'(SAD_TH) || h <= LVL_W'(SAD_TH)) begin
            m = MOOD_SAD;
        end else if (f >= LVL_W'(HAPPY_TH) && e >= LVL_W'(HAPPY_TH) &&
                     u >= LVL_W'(HAPPY_TH) && h >= LVL_W'(HAPPY_TH)) begin
            m = MOOD_HAPPY;
        end else begin
            m = MOOD_NEUTRAL;
        end
        return m;
    endfunction

    assign raw_s = {btn_heal, btn_sleep, btn_play, btn_feed};

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        btn_conditioner
`ifdef DEBOUNCE_EN
            #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
            u_cond (
                .clk   (clk),
                .reset (reset),
                .raw   (raw_s[g]),
                .press (press_s[g])
            );
    end

    assign tick_s     = (tick_cnt_r == TW'(TICK_DIV - 1));
    assign decay_ev_s = tick_s && (decay_cnt_r == DW'(DECAY_TICKS - 1));

    // Base tick divider and decay-interval counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt_r  <= '0;
            decay_cnt_r <= '0;
        end else begin
            tick_cnt_r  <= tick_s ? '0 : tick_cnt_r + TW'(1);
            if (tick_s) begin
                decay_cnt_r <= decay_ev_s ? '0 : decay_cnt_r + DW'(1);
            end else begin
                decay_cnt_r <= decay_cnt_r;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_ACTIVE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM output decode: the single accepted action this cycle.
    // In SLEEP only the sleep button means anything.
    always_comb begin
        action_s = ACT_NONE;
        case (state_r)
            ST_ACTIVE: begin
                if (press_s[BTN_HEAL])       action_s = ACT_HEAL;
                else if (press_s[BTN_FEED])  action_s = ACT_FEED;
                else if (press_s[BTN_PLAY])  action_s = ACT_PLAY;
                else if (press_s[BTN_SLEEP]) action_s = ACT_SLEEP;
                else                         action_s = ACT_NONE;
            end
            ST_SLEEP: begin
                if (press_s[BTN_SLEEP]) action_s = ACT_SLEEP;
                else                    action_s = ACT_NONE;
            end
            default: action_s = ACT_NONE;
        endcase
    end

    // FSM next-state logic; a full energy bar wakes the pet on the next cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_ACTIVE: begin
                if (action_s == ACT_SLEEP) state_nxt_s = ST_SLEEP;
                else                       state_nxt_s = ST_ACTIVE;
            end
            ST_SLEEP: begin
                if (action_s == ACT_SLEEP)                          state_nxt_s = ST_ACTIVE;
                else if (stat_r[STAT_ENERGY] == LVL_W'(MAX_LEVEL)) state_nxt_s = ST_ACTIVE;
                else                                                state_nxt_s = ST_SLEEP;
            end
            default: state_nxt_s = ST_ACTIVE;
        endcase
    end

    // Net stat change: decay first, then the action, saturated once at the end
    always_comb begin
        for (int i = 0; i < NUM_STATS; i++) begin
            delta_s[i] = '0;
        end
        if (state_r == ST_ACTIVE) begin
            if (decay_ev_s) begin
                delta_s[STAT_FOOD]   = -SW'(1);
                delta_s[STAT_FUN]    = -SW'(1);
                delta_s[STAT_ENERGY] = -SW'(1);
                // A stat at 0 or 1 is 0 after the decay step
                if (stat_r[STAT_FOOD] <= LVL_W'(1) || stat_r[STAT_ENERGY] <= LVL_W'(1)) begin
                    delta_s[STAT_HEALTH] = -SW'(1);
                end else begin
                    delta_s[STAT_HEALTH] = '0;
                end
            end else begin
                delta_s[STAT_FOOD] = '0;
            end
            case (action_s)
                ACT_HEAL: delta_s[STAT_HEALTH] = delta_s[STAT_HEALTH] + SW'(1);
                ACT_FEED: delta_s[STAT_FOOD]   = delta_s[STAT_FOOD] + SW'(2);
                ACT_PLAY: begin
                    delta_s[STAT_FUN]    = delta_s[STAT_FUN] + SW'(2);
                    delta_s[STAT_ENERGY] = delta_s[STAT_ENERGY] - SW'(1);
                end
                default: delta_s[STAT_FOOD] = delta_s[STAT_FOOD];
            endcase
        end else begin
            if (tick_s) begin
                delta_s[STAT_ENERGY] = SW'(1);
            end else begin
                delta_s[STAT_ENERGY] = '0;
            end
            if (decay_ev_s) begin
                delta_s[STAT_FOOD] = -SW'(1);
                delta_s[STAT_FUN]  = -SW'(1);
            end else begin
                delta_s[STAT_FOOD] = '0;
            end
        end
        for (int i = 0; i < NUM_STATS; i++) begin
            stat_nxt_s[i] = sat($signed({2'b00, stat_r[i]}) + delta_s[i]);
        end
    end

    // Icon selection: SLEEP pins energy, actions jump to their stat, else rotate
    always_comb begin
        icon_nxt_s = icon_r;
        rot_nxt_s  = rot_cnt_r;
        if (state_r == ST_SLEEP || state_nxt_s == ST_SLEEP) begin
            icon_nxt_s = ICON_ENERGY;
            rot_nxt_s  = '0;
        end else if (action_s != ACT_NONE) begin
            case (action_s)
                ACT_HEAL: icon_nxt_s = ICON_HEALTH;
                ACT_FEED: icon_nxt_s = ICON_FOOD;
                ACT_PLAY: icon_nxt_s = ICON_FUN;
                default:  icon_nxt_s = icon_r;
            endcase
            rot_nxt_s = '0;
        end else if (tick_s) begin
            if (rot_cnt_r == RW'(ROTATE_TICKS - 1)) begin
                icon_nxt_s = next_icon(icon_r);
                rot_nxt_s  = '0;
            end else begin
                rot_nxt_s = rot_cnt_r + RW'(1);
            end
        end else begin
            rot_nxt_s = rot_cnt_r;
        end
    end

    // Stat, icon and rotation registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_STATS; i++) begin
                stat_r[i] <= LVL_W'(INIT_LEVEL);
            end
            icon_r    <= ICON_HEALTH;
            rot_cnt_r <= '0;
        end else begin
            for (int i = 0; i < NUM_STATS; i++) begin
                stat_r[i] <= stat_nxt_s[i];
            end
            icon_r    <= icon_nxt_s;
            rot_cnt_r <= rot_nxt_s;
        end
    end

    assign sel_nxt_s = {mood_of(stat_r[STAT_FOOD], stat_r[STAT_ENERGY],
                                stat_r[STAT_FUN], stat_r[STAT_HEALTH]), icon_r};

    // Registered outputs: figure code lags the stats by one cycle, update with it
    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_r      <= {mood_of(LVL_W'(INIT_LEVEL), LVL_W'(INIT_LEVEL),
                                   LVL_W'(INIT_LEVEL), LVL_W'(INIT_LEVEL)), ICON_HEALTH};
            update_r   <= 1'b0;
            sleeping_r <= 1'b0;
        end else begin
            sel_r      <= sel_nxt_s;
            update_r   <= (sel_nxt_s != sel_r);
            sleeping_r <= (state_nxt_s == ST_SLEEP);
        end
    end

    assign select_figures = sel_r;
    assign update         = update_r;
    assign sleeping       = sleeping_r;
    assign stat_levels    = {stat_r[STAT_HEALTH], stat_r[STAT_FUN],
                             stat_r[STAT_ENERGY], stat_r[STAT_FOOD]};

endmodule

// File: tb/tb_pet_status_engine.sv
// -----------------------------------------------------------------------------
// tb_pet_status_engine
// Drives pet_status_engine (TICK_DIV=4, DECAY_TICKS=2, ROTATE_TICKS=3) with
// directed scenarios and randomized buttons/resets, and checks every cycle
// against a behavioural model of the pet rules. Literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_pet_status_engine;

    localparam int TD   = 4;
    localparam int DT   = 2;
    localparam int RT   = 3;
    localparam int MAXL = 5;
    localparam int INIT = 3;
    localparam int HTH  = 4;
    localparam int STH  = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_feed = 1'b0;
    logic        btn_play = 1'b0;
    logic        btn_sleep = 1'b0;
    logic        btn_heal = 1'b0;
    logic [3:0]  select_figures;
    logic [11:0] stat_levels;
    logic        sleeping;
    logic        update;

    int checks = 0;
    int failures = 0;

    pet_status_engine #(
        .TICK_DIV     (TD),
        .DECAY_TICKS  (DT),
        .ROTATE_TICKS (RT),
        .MAX_LEVEL    (MAXL),
        .INIT_LEVEL   (INIT),
        .HAPPY_TH     (HTH),
        .SAD_TH       (STH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_feed       (btn_feed),
        .btn_play       (btn_play),
        .btn_sleep      (btn_sleep),
        .btn_heal       (btn_heal),
        .select_figures (select_figures),
        .stat_levels    (stat_levels),
        .sleeping       (sleeping),
        .update         (update)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // stats: 0 food, 1 energy, 2 fun, 3 health
    // icon index follows the rotation order: 0 health, 1 food, 2 energy, 3 fun
    int m_stat [4];
    int m_icon;
    int m_rot;        // ticks since the rotation was last restarted
    int m_cyc;        // clock edges since reset released
    bit m_sleep;
    int m_sel;
    bit m_upd;
    bit [3:0] m_r1, m_r2, m_r3;  // raw buttons seen at the last three edges
    int icode [4] = '{0, 2, 1, 3};

    function automatic int clampv(input int v);
        return (v < 0) ? 0 : ((v > MAXL) ? MAXL : v);
    endfunction

    function automatic int mood_code(input int f, input int e, input int u, input int h);
        if (f <= STH || e <= STH || u <= STH || h <= STH) return 0;
        if (f >= HTH && e >= HTH && u >= HTH && h >= HTH) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_stat[i] = INIT;
        m_icon = 0; m_rot = 0; m_cyc = 0; m_sleep = 1'b0; m_upd = 1'b0;
        m_sel = mood_code(INIT, INIT, INIT, INIT) * 4 + icode[0];
        m_r1 = 4'b0; m_r2 = 4'b0; m_r3 = 4'b0;
    endtask

    // Advance the model by the coming clock edge using the inputs it will sample
    task automatic model_step();
        bit [3:0] raw;
        bit [3:0] p;
        int act, f, e, u, h, sel_new;
        bit tick, decay, ns;
        if (!reset) begin
            model_reset();
        end else begin
            raw = {btn_heal, btn_sleep, btn_play, btn_feed};
            p = m_r2 & ~m_r3;
            if (m_sleep) act = p[2] ? 4 : 0;
            else if (p[3]) act = 1;
            else if (p[0]) act = 2;
            else if (p[1]) act = 3;
            else if (p[2]) act = 4;
            else act = 0;
            tick  = ((m_cyc + 1) % TD) == 0;
            decay = tick && (((m_cyc + 1) / TD) % DT == 0);
            f = m_stat[0]; e = m_stat[1]; u = m_stat[2]; h = m_stat[3];
            if (!m_sleep) begin
                if (decay) begin
                    if (clampv(f - 1) == 0 || clampv(e - 1) == 0) h = h - 1;
                    f = f - 1; e = e - 1; u = u - 1;
                end
                if (act == 1) h = h + 1;
                if (act == 2) f = f + 2;
                if (act == 3) begin u = u + 2; e = e - 1; end
                ns = (act == 4);
            end else begin
                if (tick) e = e + 1;
                if (decay) begin f = f - 1; u = u - 1; end
                ns = !(act == 4 || m_stat[1] == MAXL);
            end
            sel_new = mood_code(m_stat[0], m_stat[1], m_stat[2], m_stat[3]) * 4 + icode[m_icon];
            if (m_sleep || ns) begin
                m_icon = 2; m_rot = 0;
            end else if (act != 0) begin
                m_icon = (act == 1) ? 0 : ((act == 2) ? 1 : 3);
                m_rot = 0;
            end else if (tick) begin
                m_rot++;
                if (m_rot == RT) begin m_icon = (m_icon + 1) % 4; m_rot = 0; end
            end
            m_upd = (sel_new != m_sel);
            m_sel = sel_new;
            m_stat[0] = clampv(f); m_stat[1] = clampv(e);
            m_stat[2] = clampv(u); m_stat[3] = clampv(h);
            m_sleep = ns;
            m_r3 = m_r2; m_r2 = m_r1; m_r1 = raw;
            m_cyc++;
        end
    endtask

    // Compare process: check outputs against the model, then advance it
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            chk("sel", int'(select_figures), m_sel);
            chk("stats", int'(stat_levels),
                (m_stat[3] << 9) | (m_stat[2] << 6) | (m_stat[1] << 3) | m_stat[0]);
            chk("sleeping", int'(sleeping), int'(m_sleep));
            chk("update", int'(update), int'(m_upd));
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); @(negedge clk);                 // after first active edge
        chk("rst_sel", int'(select_figures), 4'b1000);
        chk("rst_stats", int'(stat_levels), 12'h6DB);
        chk("rst_sleeping", int'(sleeping), 0);
        chk("rst_update", int'(update), 0);
        repeat (12) @(posedge clk); @(negedge clk);     // 3 ticks: icon food, neutral
        chk("rot_food_sel", int'(select_figures), 4'b1010);
        repeat (12) @(posedge clk); @(negedge clk);     // 6 ticks: icon energy, sad
        chk("rot_energy_sel", int'(select_figures), 4'b0001);
        chk("decay3_stats", int'(stat_levels), 12'h400);
        repeat (8) @(posedge clk); @(negedge clk);      // 4th decay: health 1
        chk("decay4_stats", int'(stat_levels), 12'h200);

        // Feed right after reset: food 3->5, icon food 3 cycles after the press
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1; btn_feed = 1'b1;
        @(posedge clk); #1 btn_feed = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("feed_stats", int'(stat_levels), 12'h6DD);
        @(posedge clk); @(negedge clk);
        chk("feed_sel", int'(select_figures), 4'b1010);
        chk("feed_update", int'(update), 1);
        // Second feed lands on a decay event: food 5-1+2 saturates at 5
        @(posedge clk); #1 btn_feed = 1'b1;
        @(posedge clk); #1 btn_feed = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("feed_decay_stats", int'(stat_levels), 12'h695);

        // Sleep press, then reset in the middle of SLEEP
        @(posedge clk); #1 btn_sleep = 1'b1;
        @(posedge clk); #1 btn_sleep = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("sleep_entered", int'(sleeping), 1);
        @(posedge clk); @(negedge clk);
        chk("sleep_icon", int'(select_figures[1:0]), 2'b01);
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("midrst_sel", int'(select_figures), 4'b1000);
        chk("midrst_stats", int'(stat_levels), 12'h6DB);
        chk("midrst_sleeping", int'(sleeping), 0);
        chk("midrst_update", int'(update), 0);
        @(posedge clk); #1 reset = 1'b1;

        // Randomized buttons with occasional resets
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            btn_feed  = ($urandom_range(0, 5) == 0);
            btn_play  = ($urandom_range(0, 5) == 0);
            btn_heal  = ($urandom_range(0, 7) == 0);
            btn_sleep = ($urandom_range(0, 29) == 0);
            reset     = ($urandom_range(0, 999) != 0);
        end
        @(posedge clk); #1 reset = 1'b1;
        btn_feed = 1'b0; btn_play = 1'b0; btn_heal = 1'b0; btn_sleep = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
